// File: rtl/bsg_router_credit_sender_pkg.sv
// Shared helpers for the credit-flow sender and its credit counter.
package bsg_router_credit_sender_pkg;

    // Width needed to hold a count from 0 up to and including n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bsg_router_credit_counter.sv
// Up/down saturating credit counter with async reset to init_p and sticky overflow.
module bsg_router_credit_counter
    import bsg_router_credit_sender_pkg::*;
#(
    parameter int max_p = 2,
    parameter int init_p = max_p,
    localparam int width_lp = cnt_width(max_p)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                up_i,
    input  logic                down_i,
    output logic [width_lp-1:0] count_o,
    output logic                overflow_o
);

    localparam logic [width_lp-1:0] max_lp = width_lp'(max_p);
    localparam logic [width_lp-1:0] init_lp = width_lp'(init_p);

    logic at_max;
    logic at_zero;

    assign at_max = (count_o == max_lp);
    assign at_zero = (count_o == '0);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_o <= init_lp;
            overflow_o <= 1'b0;
        end else begin
            if (up_i && !down_i) begin
                // A return with no slot outstanding saturates and is flagged.
                if (at_max) begin
                    overflow_o <= 1'b1;
                end else begin
                    count_o <= count_o + 1'b1;
                end
            end else if (down_i && !up_i && !at_zero) begin
                count_o <= count_o - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_router_credit_sender.sv
// Injects a valid/ready-and stream into a crossbar input using credit flow control.
module bsg_router_credit_sender
    import bsg_router_credit_sender_pkg::*;
#(
    parameter int width_p = 10,
    parameter int credits_p = 2,
    localparam int cnt_width_lp = cnt_width(credits_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    v_i,
    input  logic [width_p-1:0]      data_i,
    output logic                    ready_and_o,
    output logic                    v_o,
    output logic [width_p-1:0]      data_o,
    input  logic                    credit_i,
    output logic [cnt_width_lp-1:0] credit_count_o,
    output logic                    all_credits_o,
    output logic                    overflow_o
);

    localparam logic [cnt_width_lp-1:0] full_lp = cnt_width_lp'(credits_p);

    logic send;

    // Ready comes only from registered state: no path from credit_i or v_i.
    assign ready_and_o = ~reset_i & (credit_count_o != '0);
    assign send = v_i & ready_and_o;
    assign all_credits_o = (credit_count_o == full_lp);

    bsg_router_credit_counter #(
        .max_p (credits_p),
        .init_p(credits_p)
    ) counter (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .up_i      (credit_i),
        .down_i    (send),
        .count_o   (credit_count_o),
        .overflow_o(overflow_o)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v_o <= 1'b0;
            data_o <= '0;
        end else begin
            v_o <= send;
            if (send) begin
                data_o <= data_i;
            end
        end
    end

endmodule

// File: tb/tb_bsg_router_credit_sender.sv
// Directed and model-checked bench for bsg_router_credit_sender (width 10, 2 credits).
module tb_bsg_router_credit_sender;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       v_i;
    logic [9:0] data_i;
    logic       ready_and_o;
    logic       v_o;
    logic [9:0] data_o;
    logic       credit_i;
    logic [1:0] credit_count_o;
    logic       all_credits_o;
    logic       overflow_o;

    int n_checks = 0;
    int n_fail = 0;

    bsg_router_credit_sender #(
        .width_p  (10),
        .credits_p(2)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .v_i           (v_i),
        .data_i        (data_i),
        .ready_and_o   (ready_and_o),
        .v_o           (v_o),
        .data_o        (data_o),
        .credit_i      (credit_i),
        .credit_count_o(credit_count_o),
        .all_credits_o (all_credits_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all(input string tag, input int cnt, input int rdy,
                             input int v, input int ovf);
        check({tag, ".cnt"}, int'(credit_count_o), cnt);
        check({tag, ".rdy"}, int'(ready_and_o), rdy);
        check({tag, ".v"}, int'(v_o), v);
        check({tag, ".ovf"}, int'(overflow_o), ovf);
        check({tag, ".all"}, int'(all_credits_o), int'(cnt == 2));
    endtask

    logic [9:0] sent_q[$];
    logic [9:0] fifo_q[$];
    logic [9:0] exp_d;
    int m;
    bit s;

    initial begin
        reset_i = 1'b1;
        v_i = 1'b0;
        data_i = '0;
        credit_i = 1'b0;

        // Reset state while reset is held.
        #3;
        check_all("rst", 2, 0, 0, 0);
        check("rst.data", int'(data_o), 0);
        step();
        reset_i = 1'b0;
        #1;
        check_all("rel", 2, 1, 0, 0);

        // Two sends drain both credits; third flit is held off.
        v_i = 1'b1;
        data_i = 10'h001;
        step();
        check_all("s1", 1, 1, 1, 0);
        check("s1.data", int'(data_o), 'h001);
        data_i = 10'h002;
        step();
        check_all("s2", 0, 0, 1, 0);
        check("s2.data", int'(data_o), 'h002);
        data_i = 10'h003;
        step();
        check_all("s3", 0, 0, 0, 0);
        check("s3.data", int'(data_o), 'h002);

        // Credit at zero: ready rises next cycle, no bypass.
        credit_i = 1'b1;
        step();
        check_all("z1", 1, 1, 0, 0);
        credit_i = 1'b0;
        step();
        check_all("z2", 0, 0, 1, 0);
        check("z2.data", int'(data_o), 'h003);
        v_i = 1'b0;

        // Bring count to 1, then send+credit together for 10 cycles.
        credit_i = 1'b1;
        step();
        check_all("c1", 1, 1, 0, 0);
        v_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_i = 10'(16 + i);
            step();
            check_all($sformatf("bb%0d", i), 1, 1, 1, 0);
            check($sformatf("bb%0d.data", i), int'(data_o), 16 + i);
        end
        v_i = 1'b0;
        step();
        check_all("full", 2, 1, 0, 0);

        // Credit at full count: saturates and sets the sticky flag.
        step();
        check_all("ovf", 2, 1, 0, 1);
        credit_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            v_i = (i % 2 == 0);
            credit_i = (i % 2 == 1);
            data_i = 10'(i);
            step();
        end
        v_i = 1'b0;
        credit_i = 1'b0;
        check_all("stk", 2, 1, 0, 1);

        // Async reset mid-cycle with a flit in flight and zero credits.
        v_i = 1'b1;
        data_i = 10'h155;
        step();
        step();
        v_i = 1'b0;
        check_all("pre", 0, 0, 1, 1);
        #2;
        reset_i = 1'b1;
        #1;
        check_all("arst", 2, 0, 0, 0);
        check("arst.data", int'(data_o), 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        step();

        // Random traffic against a 2-deep downstream FIFO model.
        m = 2;
        for (int c = 0; c < 400; c++) begin
            if (v_o) begin
                exp_d = sent_q.pop_front();
                check("rnd.data", int'(data_o), int'(exp_d));
                fifo_q.push_back(data_o);
                if (fifo_q.size() > 2) check("rnd.fifo", fifo_q.size(), 2);
            end
            check("rnd.cnt", int'(credit_count_o), m);
            credit_i = (fifo_q.size() > 0) && ($urandom_range(0, 1) == 1);
            if (credit_i) void'(fifo_q.pop_front());
            v_i = ($urandom_range(0, 3) != 0);
            data_i = 10'($urandom);
            s = v_i && (m != 0);
            if (s) sent_q.push_back(data_i);
            m = m - int'(s) + int'(credit_i);
            step();
        end
        check("rnd.ovf", int'(overflow_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bsg_router_credit_sender.md
Name: bsg_router_credit_sender

Overview:
- Upstream injection stage for one `bsg_router_crossbar_o_by_i` input port, e.g. a processor or local port.
- Converts a producer's valid/ready-and stream into credit-flow traffic toward the crossbar input FIFO.
- Tracks available downstream FIFO slots with a credit counter and launches registered flits only when a credit exists.
- Consumes the per-input credit pulses that the crossbar returns on its `credit_ready_and_o` bit.

Parameters:
- width_p, 10: flit width in bits.
- credits_p, 2: downstream input FIFO depth. Equals the initial and maximum credit count. Must be ≥ 1.
- cnt_width_lp, `$clog2(credits_p+1)`: derived credit counter width. Not user-settable.

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- v_i  in  1  producer flit valid.
- data_i  in  width_p  producer flit.
- ready_and_o  out  1  high when this block will take `data_i` this cycle.
- v_o  out  1  flit valid toward the crossbar `valid_i`. One-cycle pulse per flit; no ready is checked.
- data_o  out  width_p  flit toward the crossbar `data_i`.
- credit_i  in  1  credit return pulse from the crossbar. One pulse is one freed FIFO slot.
- credit_count_o  out  cnt_width_lp  current available credits.
- all_credits_o  out  1  `credit_count_o == credits_p`; used to detect quiescence or drain.
- overflow_o  out  1  sticky error: a credit was returned while the count was already at `credits_p`.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - `credit_count_o = credits_p`, `v_o = 0`, `data_o = 0`, `overflow_o = 0`.
  - `all_credits_o = 1`, `ready_and_o = 0` while `reset_i` is high.
- `ready_and_o = ~reset_i & (credit_count_o != 0)`.
  - Driven only from the registered count, so there is no combinational path from `credit_i` or `v_i`.
- Send: `send = v_i & ready_and_o`.
  - The next edge registers `data_o <= data_i` and sets `v_o <= 1`.
  - Latency `v_i` to `v_o` is exactly 1 cycle.
  - Back-to-back sends are allowed every cycle while credits remain.
- When there is no send, the next edge sets `v_o <= 0` and `data_o` holds its last value.
- Counter update each edge:
  - `send & ~credit_i`: count - 1.
  - `~send & credit_i`: count + 1.
  - Both: unchanged.
  - Neither: unchanged.
- Zero credits: `ready_and_o = 0`, so no send can occur. A `credit_i` in that cycle sets count to 1, and `ready_and_o` rises the following cycle. A same-cycle bypass is forbidden.
- Overflow: `credit_i` with `~send` while count == `credits_p`.
  - Count saturates at `credits_p`.
  - `overflow_o` sets on the next edge and holds until reset.
  - `credit_i` with send while count == `credits_p` is legal (net unchanged).
- Count never underflows; this is guaranteed by `ready_and_o` gating.
- Reset mid-stream: in-flight `v_o` drops immediately and the count restores to `credits_p`. The crossbar must be reset in the same cycle; credits already in flight are discarded.
- `credit_i` and `v_i` are don't-care while `reset_i` is high.
- No state machine beyond the counter and the output register. State consists of the counter, the `v_o`/`data_o` register and the sticky flag.

Decomposition:
- No new package typedefs. Use existing `bsg_noc_links.svh` conventions; no new link structs are needed.
- Sub-module `bsg_router_credit_counter`:
  - Parameters: `max_p`, `init_p`.
  - Inputs: `up_i`, `down_i`.
  - Outputs: `count_o`, `overflow_o`.
  - Behaviour: up/down saturating counter with async reset to `init_p` and sticky overflow.
  - Reused later for multi-VC senders.
- Top level holds the data/valid output register and the `ready_and_o` logic.

Test Plan (width_p=10, credits_p=2):
- Reset release, `v_i=0` → `credit_count_o=2`, `all_credits_o=1`, `ready_and_o=1`, `v_o=0`, `overflow_o=0`.
- `v_i=1`, data 0x001, 0x002, 0x003 in consecutive cycles, `credit_i=0` → `v_o` pulses 0x001 then 0x002 in cycles 1 and 2. Count goes 2→1→0, `ready_and_o=0` in the third cycle, and 0x003 is held by the producer.
- From count=0, `credit_i=1` for one cycle, `v_i=1` data 0x003 → `ready_and_o` rises the next cycle, `v_o` 0x003 one cycle later, count ends at 0.
- Count=1, `send` and `credit_i` in the same cycle repeated 10 cycles with data 0x010..0x019 → count stays 1, `v_o` high 10 consecutive cycles with matching data in order.
- Count=2, `credit_i=1`, `v_i=0` → count stays 2 and `overflow_o=1` from the next cycle onward, still 1 after 20 cycles of normal traffic.
- Assert `reset_i` asynchronously mid-cycle while `v_o=1` and count=0 → `v_o=0`, count=2 and `overflow_o=0` immediately, before the next clock edge.
- Chain with `bsg_router_crossbar_o_by_i` (i_els_p=2, credits_p equal to its FIFO depth), ready tied high → no flit dropped, `overflow_o` never set over 5000 random cycles.
